// File: rtl/conv_y_deskew.sv
// conv_y_deskew
//
// Realigns the skewed output lanes of the convolution systolic array and
// buffers whole result vectors for the writeback stage.
//
// The array emits lane i of a result vector i cycles after lane 0. Each lane
// is delayed by P-1-i registers so that every lane of one vector lines up on
// the same cycle. The aligned {y1, y2} word is written into a DEPTH-entry
// circular FIFO. The array cannot stall, so the block reports occupancy-based
// back-pressure (almost_full) and a sticky drop flag (ovf).
//
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   in_vld       lane 0 of in_y1/in_y2 carries a result this cycle
//   in_y1/in_y2  P x 32-bit skewed lanes, lane i at [i*32 +: 32]
//   out_vld      FIFO head is valid
//   out_rdy      consumer accepts the head
//   out_y1/y2    aligned head vector
//   cnt          FIFO occupancy, 0..DEPTH
//   almost_full  scheduler must stop issuing result vectors
//   ovf          sticky: an aligned vector was dropped
//
// Handshake: a head word transfers on every rising edge where out_vld and
// out_rdy are both high. While out_vld is high and out_rdy is low, out_y1,
// out_y2 and out_vld hold. out_rdy has no effect while out_vld is low.
//
// P must be at least 2 and DEPTH at least 2.

module conv_y_deskew #(
   parameter int P     = 16,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_vld,
   input  logic [P*32-1:0]   in_y1,
   input  logic [P*32-1:0]   in_y2,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [P*32-1:0]   out_y1,
   output logic [P*32-1:0]   out_y2,
   output logic [CW-1:0]     cnt,
   output logic              almost_full,
   output logic              ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WW = 2 * P * 32;
   // Wide enough to hold cnt + pend without wrapping.
   localparam int SW = $clog2(DEPTH + P + 1) + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [AW-1:0] LAST_P  = AW'(DEPTH - 1);
   localparam logic [SW-1:0] AF_LVL  = SW'(DEPTH - 1);

   // ---------------------------------------------------------------------
   // Deskew pipeline
   // ---------------------------------------------------------------------
   logic [P*32-1:0] y1_al;
   logic [P*32-1:0] y2_al;
   logic [P-2:0]    vpipe;
   logic            wr_vld;

   for (genvar i = 0; i < P; i++) begin : g_lane
      localparam int D = P - 1 - i;
      if (D == 0) begin : g_nodly
         // Last lane arrives already aligned with the rest.
         assign y1_al[i*32 +: 32] = in_y1[i*32 +: 32];
         assign y2_al[i*32 +: 32] = in_y2[i*32 +: 32];
      end else begin : g_dly
         logic [31:0] sr1 [D];
         logic [31:0] sr2 [D];
         // Data path carries no reset; validity is tracked by vpipe.
         always_ff @(posedge clk) begin
            sr1[0] <= in_y1[i*32 +: 32];
            sr2[0] <= in_y2[i*32 +: 32];
            for (int k = 1; k < D; k++) begin
               sr1[k] <= sr1[k-1];
               sr2[k] <= sr2[k-1];
            end
         end
         assign y1_al[i*32 +: 32] = sr1[D-1];
         assign y2_al[i*32 +: 32] = sr2[D-1];
      end
   end

   assign wr_vld = vpipe[P-2];

   // ---------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------
   logic [WW-1:0] mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          rd;
   logic          wr;

   assign out_vld = (cnt != '0);
   assign rd      = out_vld & out_rdy;
   // A full FIFO still takes a write on a cycle its head is being read;
   // at full wp == rp, and the overwritten slot is the one leaving.
   assign wr      = wr_vld & ((cnt < DEPTH_C) | rd);

   assign out_y1 = mem[rp][WW-1 -: P*32];
   assign out_y2 = mem[rp][P*32-1:0];

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= {y1_al, y2_al};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vpipe <= '0;
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         vpipe[0] <= in_vld;
         for (int k = 1; k < P - 1; k++) vpipe[k] <= vpipe[k-1];

         if (wr) wp <= (wp == LAST_P) ? '0 : wp + 1'b1;
         if (rd) rp <= (rp == LAST_P) ? '0 : rp + 1'b1;

         case ({wr, rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase

         if (wr_vld && !wr) ovf <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Back-pressure: stored vectors plus vectors still crossing the deskew
   // pipeline. Built from registers only, so in_vld has no path here.
   // ---------------------------------------------------------------------
   logic [SW-1:0] pend;
   logic [SW-1:0] total;

   always_comb begin
      pend = '0;
      for (int k = 0; k < P - 1; k++) pend = pend + SW'(vpipe[k]);
      total       = SW'(cnt) + pend;
      almost_full = (total >= AF_LVL);
   end

endmodule

// File: tb/tb_conv_y_deskew.sv
// Bench for conv_y_deskew at P=4, DEPTH=4. The driver keeps a four-deep
// history of issued vectors so that lane i on the input bus always carries
// lane i of the vector issued i cycles earlier. Expected words are queued
// at issue time; a negedge monitor pops and compares on every transfer.

module tb_conv_y_deskew;

   localparam int P     = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int W     = 2 * P * 32;

   logic              clk;
   logic              rstn;
   logic              in_vld;
   logic [P*32-1:0]   in_y1;
   logic [P*32-1:0]   in_y2;
   logic              out_vld;
   logic              out_rdy;
   logic [P*32-1:0]   out_y1;
   logic [P*32-1:0]   out_y2;
   logic [CW-1:0]     cnt;
   logic              almost_full;
   logic              ovf;

   conv_y_deskew #(.P(P), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_vld      (in_vld),
      .in_y1       (in_y1),
      .in_y2       (in_y2),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_y1      (out_y1),
      .out_y2      (out_y2),
      .cnt         (cnt),
      .almost_full (almost_full),
      .ovf         (ovf)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0]    exp_q[$];
   int              checks   = 0;
   int              failures = 0;
   logic [P*32-1:0] hist_y1 [P];
   logic [P*32-1:0] hist_y2 [P];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [P*32-1:0] mk_y1(input int n);
      logic [P*32-1:0] v;
      for (int i = 0; i < P; i++) v[i*32 +: 32] = (32'(n) << 16) | (32'h100 + 32'(i));
      return v;
   endfunction

   function automatic logic [P*32-1:0] mk_y2(input int n);
      logic [P*32-1:0] v;
      for (int i = 0; i < P; i++) v[i*32 +: 32] = (32'(n) << 16) | (32'h200 + 32'(i));
      return v;
   endfunction

   // ---------------- driver ----------------
   // One call = one clock cycle. Returns 1 time unit after the rising edge.
   task automatic cycle(input logic v, input int n, input logic push, input logic rdy);
      for (int k = P - 1; k > 0; k--) begin
         hist_y1[k] = hist_y1[k-1];
         hist_y2[k] = hist_y2[k-1];
      end
      hist_y1[0] = v ? mk_y1(n) : {P{32'hdeadbeef}};
      hist_y2[0] = v ? mk_y2(n) : {P{32'hbadc0ffe}};
      for (int i = 0; i < P; i++) begin
         in_y1[i*32 +: 32] = hist_y1[i][i*32 +: 32];
         in_y2[i*32 +: 32] = hist_y2[i][i*32 +: 32];
      end
      in_vld  = v;
      out_rdy = rdy;
      if (push) exp_q.push_back({mk_y1(n), mk_y2(n)});
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rstn === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("out_unexpected_qsize", W'(exp_q.size()), W'(1));
         end else begin
            chk("out_data", {out_y1, out_y2}, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int   issued;
      int   cyc;
      logic r;
      logic v;

      for (int k = 0; k < P; k++) begin
         hist_y1[k] = '0;
         hist_y2[k] = '0;
      end
      rstn    = 1'b0;
      in_vld  = 1'b0;
      in_y1   = '0;
      in_y2   = '0;
      out_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("rst_out_vld", W'(out_vld), W'(0));
      chk("rst_cnt", W'(cnt), W'(0));
      chk("rst_af", W'(almost_full), W'(0));
      chk("rst_ovf", W'(ovf), W'(0));
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // ---- single vector: in_vld at t, head valid at t+4 ----
      cycle(1'b1, 0, 1'b1, 1'b0);       // t
      cycle(1'b0, 0, 1'b0, 1'b0);       // t+1
      cycle(1'b0, 0, 1'b0, 1'b0);       // t+2
      chk("t1_vld_early", W'(out_vld), W'(0));
      cycle(1'b0, 0, 1'b0, 1'b0);       // t+3, wr_vld
      chk("t1_vld_t4", W'(out_vld), W'(1));
      chk("t1_cnt", W'(cnt), W'(1));
      chk("t1_y1", W'(out_y1), W'({32'h103, 32'h102, 32'h101, 32'h100}));
      chk("t1_y2", W'(out_y2), W'({32'h203, 32'h202, 32'h201, 32'h200}));
      cycle(1'b0, 0, 1'b0, 1'b1);       // drain
      chk("t1_cnt_drained", W'(cnt), W'(0));
      cycle(1'b0, 0, 1'b0, 1'b1);       // rdy with empty FIFO
      chk("t1_idle_rdy_cnt", W'(cnt), W'(0));

      // ---- burst of 3 with back-pressure ----
      cycle(1'b1, 1, 1'b1, 1'b0);
      cycle(1'b1, 2, 1'b1, 1'b0);
      cycle(1'b1, 3, 1'b1, 1'b0);
      chk("t2_af_inflight", W'(almost_full), W'(1));
      chk("t2_cnt_inflight", W'(cnt), W'(0));
      repeat (3) cycle(1'b0, 0, 1'b0, 1'b0);
      chk("t2_cnt3", W'(cnt), W'(3));
      chk("t2_af", W'(almost_full), W'(1));
      repeat (3) cycle(1'b0, 0, 1'b0, 1'b1);
      chk("t2_cnt_drained", W'(cnt), W'(0));
      chk("t2_af_drained", W'(almost_full), W'(0));

      // ---- full plus simultaneous read/write ----
      for (int n = 4; n <= 8; n++) cycle(1'b1, n, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 0, 1'b0, 1'b0);
      chk("t3_cnt_full", W'(cnt), W'(4));
      cycle(1'b0, 0, 1'b0, 1'b1);       // 5th wr_vld meets a read
      chk("t3_cnt_stays", W'(cnt), W'(4));
      chk("t3_ovf", W'(ovf), W'(0));
      repeat (4) cycle(1'b0, 0, 1'b0, 1'b1);
      chk("t3_cnt_drained", W'(cnt), W'(0));

      // ---- pointer wrap, scheduler honours almost_full ----
      issued = 0;
      cyc    = 0;
      r      = 1'b1;
      while ((issued < 10 || exp_q.size() != 0) && cyc < 200) begin
         v = (issued < 10) && (almost_full == 1'b0);
         cycle(v, 20 + issued, v, r);
         if (v) issued++;
         r = ~r;
         cyc++;
         chk("wrap_cnt_le4", W'(cnt <= CW'(DEPTH)), W'(1));
      end
      chk("wrap_timeout", W'(cyc < 200), W'(1));
      chk("wrap_issued", W'(issued), W'(10));
      chk("wrap_ovf", W'(ovf), W'(0));
      repeat (2) cycle(1'b0, 0, 1'b0, 1'b1);
      chk("wrap_cnt_end", W'(cnt), W'(0));

      // ---- overflow ----
      for (int n = 9; n <= 12; n++) cycle(1'b1, n, 1'b1, 1'b0);
      cycle(1'b1, 13, 1'b0, 1'b0);      // dropped: not expected at output
      repeat (2) cycle(1'b0, 0, 1'b0, 1'b0);
      chk("t4_cnt_full", W'(cnt), W'(4));
      chk("t4_ovf_before", W'(ovf), W'(0));
      cycle(1'b0, 0, 1'b0, 1'b0);       // drop cycle
      chk("t4_ovf_set", W'(ovf), W'(1));
      chk("t4_cnt_kept", W'(cnt), W'(4));
      repeat (4) cycle(1'b0, 0, 1'b0, 1'b1);
      chk("t4_cnt_drained", W'(cnt), W'(0));
      chk("t4_ovf_sticky", W'(ovf), W'(1));

      // ---- reset mid-burst: 2 stored, 2 in flight ----
      for (int n = 40; n <= 43; n++) cycle(1'b1, n, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b0, 1'b0);
      chk("t6_cnt2", W'(cnt), W'(2));
      #2;
      rstn = 1'b0;
      exp_q.delete();
      #1;
      chk("t6_rst_vld", W'(out_vld), W'(0));
      chk("t6_rst_cnt", W'(cnt), W'(0));
      chk("t6_rst_ovf", W'(ovf), W'(0));
      chk("t6_rst_af", W'(almost_full), W'(0));
      @(posedge clk);
      #3;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, 0, 1'b0, 1'b1);
         chk("t6_no_stale", W'(out_vld), W'(0));
      end
      // A fresh vector after reset still flows through intact.
      cycle(1'b1, 50, 1'b1, 1'b1);
      repeat (5) cycle(1'b0, 0, 1'b0, 1'b1);
      chk("t6_fresh_cnt", W'(cnt), W'(0));

      chk("final_queue_empty", W'(exp_q.size()), W'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
